// File: rtl/alpha_sequencer.sv
// alpha_sequencer
// Walks the CORDIC iteration schedule for one job and presents each step
// ({shift, alphai, last}) to the rotation stage over a valid/ready handshake.
// It holds the circular (atan), linear (2^-i) and hyperbolic (atanh)
// elementary-angle tables and selects one per job from the latched mode.
// Hyperbolic jobs start at i=1 and repeat i at 4, 13, 40, ...
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset; aborts any job with no done pulse
//   start   job request, honoured only in IDLE and not in the done cycle
//   mode    2'b01 circular, 2'b00 linear, 2'b11 hyperbolic, 2'b10 illegal
//   ready   consumer accepts the current step
//   busy    job in progress
//   valid   shift/alphai/last hold a step
//   shift   iteration index i
//   alphai  table entry for i in the latched mode
//   last    current step is the final step of the job
//   done    one-cycle pulse after the final step is accepted
//   err     one-cycle pulse on start with the illegal mode
module alpha_sequencer #(
    parameter int DEC      = 2,
    parameter int FRAC     = 14,
    parameter int ITER     = FRAC + 1,
    parameter int L        = DEC + FRAC,
    parameter int LOG_ITER = $clog2(ITER)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic                ready,
    output logic                busy,
    output logic                valid,
    output logic [LOG_ITER-1:0] shift,
    output logic [L-1:0]        alphai,
    output logic                last,
    output logic                done,
    output logic                err
);

    localparam logic [1:0] MODE_LIN  = 2'b00;
    localparam logic [1:0] MODE_CIRC = 2'b01;
    localparam logic [1:0] MODE_BAD  = 2'b10;
    localparam logic [1:0] MODE_HYP  = 2'b11;

    // k needs two extra bits so 3k+1 does not wrap before passing ITER-1
    localparam int                  KW       = LOG_ITER + 2;
    localparam logic [KW-1:0]       K_INIT   = KW'(4);
    localparam logic [LOG_ITER-1:0] LAST_IDX = LOG_ITER'(ITER - 1);
    localparam logic [LOG_ITER:0]   ITER_W   = (LOG_ITER + 1)'(ITER);

    typedef enum logic {IDLE, RUN} state_t;

    // Table entries are computed at elaboration from their defining
    // functions, rounded to nearest in the FRAC-bit fixed-point format.
    function automatic logic [L-1:0] table_entry(input int sel, input int i);
        real x;
        real s;
        real v;
        x = 1.0;
        s = 1.0;
        for (int n = 0; n < i; n++) x = x / 2.0;
        for (int n = 0; n < FRAC; n++) s = s * 2.0;
        case (sel)
            0:       v = $atan(x);
            1:       v = x;
            default: v = (i == 0) ? 0.0 : $atanh(x);
        endcase
        return L'($rtoi(v * s + 0.5));
    endfunction

    // A step is final at i=ITER-1 unless that index still owes its repeat
    function automatic logic step_is_last(input logic [LOG_ITER-1:0] i,
                                          input logic rep_f,
                                          input logic [KW-1:0] kk,
                                          input logic hyp);
        return (i == LAST_IDX) && !(hyp && ({2'b00, i} == kk) && !rep_f);
    endfunction

    logic [L-1:0] circ_tab [ITER];
    logic [L-1:0] lin_tab  [ITER];
    logic [L-1:0] hyp_tab  [ITER];

    for (genvar g = 0; g < ITER; g++) begin : g_tab
        assign circ_tab[g] = table_entry(0, g);
        assign lin_tab[g]  = table_entry(1, g);
        assign hyp_tab[g]  = table_entry(2, g);
    end

    state_t                state, state_nx;
    logic [1:0]            mode_q, mode_nx;
    logic [LOG_ITER-1:0]   idx, idx_nx;
    logic                  rep, rep_nx;
    logic [KW-1:0]         k, k_nx;
    logic                  last_nx, done_nx, err_nx;
    logic                  load_step;
    logic [L-1:0]          rd_val;
    logic                  hyp_q;
    logic                  at_k;

    assign hyp_q = (mode_q == MODE_HYP);
    assign at_k  = ({2'b00, idx} == k);

    always_comb begin
        state_nx  = state;
        mode_nx   = mode_q;
        idx_nx    = idx;
        rep_nx    = rep;
        k_nx      = k;
        last_nx   = last;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        load_step = 1'b0;
        case (state)
            IDLE: begin
                if (start && !done) begin
                    if (mode == MODE_BAD) begin
                        err_nx = 1'b1;
                    end else begin
                        state_nx  = RUN;
                        mode_nx   = mode;
                        idx_nx    = (mode == MODE_HYP) ? LOG_ITER'(1) : '0;
                        rep_nx    = 1'b0;
                        k_nx      = K_INIT;
                        load_step = 1'b1;
                        last_nx   = step_is_last(idx_nx, 1'b0, K_INIT, mode == MODE_HYP);
                    end
                end
            end
            RUN: begin
                if (ready) begin
                    if (last) begin
                        state_nx = IDLE;
                        last_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        load_step = 1'b1;
                        if (hyp_q && at_k && !rep) begin
                            rep_nx = 1'b1;
                        end else begin
                            idx_nx = idx + LOG_ITER'(1);
                            rep_nx = 1'b0;
                            // Repeat point just served: move to the next one
                            if (hyp_q && at_k) k_nx = k + (k << 1) + KW'(1);
                        end
                        last_nx = step_is_last(idx_nx, rep_nx, k_nx, hyp_q);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Table read for the step about to be registered
    always_comb begin
        rd_val = '0;
        if ({1'b0, idx_nx} < ITER_W) begin
            case (mode_nx)
                MODE_CIRC: rd_val = circ_tab[idx_nx];
                MODE_LIN:  rd_val = lin_tab[idx_nx];
                MODE_HYP:  rd_val = hyp_tab[idx_nx];
                default:   rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= MODE_LIN;
            idx    <= '0;
            rep    <= 1'b0;
            k      <= K_INIT;
            last   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            alphai <= '0;
        end else begin
            state  <= state_nx;
            mode_q <= mode_nx;
            idx    <= idx_nx;
            rep    <= rep_nx;
            k      <= k_nx;
            last   <= last_nx;
            done   <= done_nx;
            err    <= err_nx;
            if (load_step) alphai <= rd_val;
        end
    end

    assign busy  = (state == RUN);
    assign valid = (state == RUN);
    assign shift = idx;

endmodule

// File: tb/tb_alpha_sequencer.sv
module tb_alpha_sequencer;

    localparam int DEC  = 2;
    localparam int FRAC = 14;
    localparam int ITER = FRAC + 1;
    localparam int L    = DEC + FRAC;
    localparam int LW   = $clog2(ITER);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic          ready;
    logic          busy;
    logic          valid;
    logic [LW-1:0] shift;
    logic [L-1:0]  alphai;
    logic          last;
    logic          done;
    logic          err;

    alpha_sequencer #(.DEC(DEC), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .ready(ready),
        .busy(busy), .valid(valid), .shift(shift), .alphai(alphai),
        .last(last), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // round(atan(2^-i) * 2^14) and round(atanh(2^-i) * 2^14), worked by hand
    int circ_ref [15] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1};
    int hyp_ref  [15] = '{0, 9000, 4185, 2059, 1025, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1};

    int exp_sh[$];
    int exp_al[$];

    task automatic build(input logic [1:0] m);
        exp_sh.delete();
        exp_al.delete();
        if (m == 2'b11) begin
            for (int s = 1; s < ITER; s++) begin
                exp_sh.push_back(s);
                exp_al.push_back(hyp_ref[s]);
                if (s == 4 || s == 13) begin
                    exp_sh.push_back(s);
                    exp_al.push_back(hyp_ref[s]);
                end
            end
        end else begin
            for (int s = 0; s < ITER; s++) begin
                exp_sh.push_back(s);
                exp_al.push_back((m == 2'b01) ? circ_ref[s] : (16384 >> s));
            end
        end
    endtask

    // pat 0: ready always high; pat 1: ready repeats 1,0,0,1
    task automatic run_job(input logic [1:0] m, input int pat, input bit poke, input string nm);
        int n;
        int j;
        int cyc;
        bit r;
        build(m);
        n = exp_sh.size();
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        mode  = (m == 2'b00) ? 2'b11 : 2'b00;
        j   = 0;
        cyc = 0;
        while (j < n && cyc < 200) begin
            check({nm, "_valid"}, 32'(valid), 32'd1);
            check({nm, "_busy"}, 32'(busy), 32'd1);
            check({nm, "_shift"}, 32'(shift), 32'(exp_sh[j]));
            check({nm, "_alphai"}, 32'(alphai), 32'(exp_al[j]));
            check({nm, "_last"}, 32'(last), 32'(j == n - 1));
            check({nm, "_done"}, 32'(done), 32'd0);
            r = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            ready = r;
            start = poke && (cyc == 3);
            if (poke) mode = 2'b01;
            @(negedge clk);
            if (r) j++;
            cyc++;
        end
        start = 1'b0;
        check({nm, "_steps"}, 32'(j), 32'(n));
        check({nm, "_done_pulse"}, 32'(done), 32'd1);
        check({nm, "_busy_off"}, 32'(busy), 32'd0);
        check({nm, "_valid_off"}, 32'(valid), 32'd0);
        // start during the done cycle must be ignored
        start = 1'b1;
        mode  = 2'b01;
        @(negedge clk);
        start = 1'b0;
        ready = 1'b0;
        check({nm, "_done_clear"}, 32'(done), 32'd0);
        check({nm, "_idle_gap"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({nm, "_still_idle"}, 32'(valid), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        mode  = 2'b00;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_shift", 32'(shift), 32'd0);
        check("rst_alphai", 32'(alphai), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        run_job(2'b01, 0, 1'b0, "circ");
        run_job(2'b00, 0, 1'b0, "lin");
        run_job(2'b11, 0, 1'b1, "hyp");
        run_job(2'b01, 1, 1'b0, "circ_tog");

        // illegal mode
        @(negedge clk);
        start = 1'b1;
        mode  = 2'b10;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", 32'(err), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("err_clear", 32'(err), 32'd0);
        check("err_busy2", 32'(busy), 32'd0);

        // reset in the middle of a circular job
        @(negedge clk);
        start = 1'b1;
        mode  = 2'b01;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_shift5", 32'(shift), 32'd5);
        check("mid_alpha5", 32'(alphai), 32'd512);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_alphai", 32'(alphai), 32'd0);
        check("mid_rst_shift", 32'(shift), 32'd0);
        @(negedge clk);
        check("mid_rst_done", 32'(done), 32'd0);
        rst   = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        check("mid_rst_done2", 32'(done), 32'd0);

        run_job(2'b01, 0, 1'b0, "circ_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
